// File: rtl/ddr_rx_deserializer.sv
// DDR receive deserializer: pairs rise/fall captures into words (DDR) or rise-only nibble pairs.
// Optional saturating error counter enabled by DDR_RX_DESERIALIZER_ERROR_COUNT_EN.
module ddr_rx_deserializer #(
  parameter int DATA_WIDTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   ddr_data,
  input  logic                    ddr_control,
  input  logic                    nibble_mode,
  output logic [2*DATA_WIDTH-1:0] output_data,
  output logic                    output_valid,
  output logic                    output_error,
  output logic                    frame_start,
  output logic                    frame_end
`ifdef DDR_RX_DESERIALIZER_ERROR_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0]  error_count
`endif
);

  if (DATA_WIDTH < 1) begin : g_data_width_check
    $error("DATA_WIDTH must be at least 1");
  end
  if (COUNT_WIDTH < 1) begin : g_count_width_check
    $error("COUNT_WIDTH must be at least 1");
  end

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    DDR_ACTIVE,
    NIBBLE_LOW,
    NIBBLE_HIGH
  } state_t;

  logic [DATA_WIDTH-1:0] rise_data;
  logic                  rise_ctl;
  logic                  rise_seen;
  logic [DATA_WIDTH-1:0] fall_data;
  logic                  fall_ctl;
  logic                  beat_ready;

  logic beat_dv;
  logic beat_err;

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] low_data;
  logic [DATA_WIDTH-1:0] next_low_data;
  logic                  low_error;
  logic                  next_low_error;
  logic                  first_pending;
  logic                  next_first_pending;

  logic [2*DATA_WIDTH-1:0] next_data;
  logic                    next_valid;
  logic                    next_error;
  logic                    next_frame_start;
  logic                    next_frame_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rise_data <= '0;
      rise_ctl  <= 1'b0;
      rise_seen <= 1'b0;
    end else begin
      rise_data <= ddr_data;
      rise_ctl  <= ddr_control;
      rise_seen <= 1'b1;
    end
  end

  // beat_ready only rises once a posedge capture has been followed by its
  // negedge capture, so reset-cleared rise registers are never taken as a beat.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      fall_data  <= '0;
      fall_ctl   <= 1'b0;
      beat_ready <= 1'b0;
    end else begin
      fall_data  <= ddr_data;
      fall_ctl   <= ddr_control;
      beat_ready <= rise_seen;
    end
  end

  assign beat_dv  = rise_ctl;
  assign beat_err = rise_ctl ^ fall_ctl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= SYNC;
      low_data      <= '0;
      low_error     <= 1'b0;
      first_pending <= 1'b0;
      output_data   <= '0;
      output_valid  <= 1'b0;
      output_error  <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
    end else begin
      state         <= next_state;
      low_data      <= next_low_data;
      low_error     <= next_low_error;
      first_pending <= next_first_pending;
      output_data   <= next_data;
      output_valid  <= next_valid;
      output_error  <= next_error;
      frame_start   <= next_frame_start;
      frame_end     <= next_frame_end;
    end
  end

  always_comb begin
    next_state         = state;
    next_low_data      = low_data;
    next_low_error     = low_error;
    next_first_pending = first_pending;
    next_data          = output_data;
    next_valid         = 1'b0;
    next_error         = 1'b0;
    next_frame_start   = 1'b0;
    next_frame_end     = 1'b0;

    if (beat_ready) begin
      case (state)
        SYNC: begin
          if (!beat_dv) next_state = IDLE;
        end

        IDLE: begin
          if (beat_dv) begin
            if (nibble_mode) begin
              next_low_data      = rise_data;
              next_low_error     = beat_err;
              next_first_pending = 1'b1;
              next_state         = NIBBLE_HIGH;
            end else begin
              next_data        = {fall_data, rise_data};
              next_valid       = 1'b1;
              next_error       = beat_err;
              next_frame_start = 1'b1;
              next_state       = DDR_ACTIVE;
            end
          end
        end

        DDR_ACTIVE: begin
          if (beat_dv) begin
            next_data  = {fall_data, rise_data};
            next_valid = 1'b1;
            next_error = beat_err;
          end else begin
            next_frame_end = 1'b1;
            next_state     = IDLE;
          end
        end

        NIBBLE_HIGH: begin
          if (beat_dv) begin
            next_data          = {rise_data, low_data};
            next_valid         = 1'b1;
            next_error         = low_error | beat_err;
            next_frame_start   = first_pending;
            next_first_pending = 1'b0;
            next_state         = NIBBLE_LOW;
          end else begin
            // Odd nibble count: the stored half-word is dropped and flagged.
            next_frame_end = 1'b1;
            next_error     = 1'b1;
            next_state     = IDLE;
          end
        end

        NIBBLE_LOW: begin
          if (beat_dv) begin
            next_low_data  = rise_data;
            next_low_error = beat_err;
            next_state     = NIBBLE_HIGH;
          end else begin
            next_frame_end = 1'b1;
            next_state     = IDLE;
          end
        end

        default: next_state = SYNC;
      endcase
    end
  end

`ifdef DDR_RX_DESERIALIZER_ERROR_COUNT_EN
  // Counts in step with output_error so both change on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_count <= '0;
    end else if (next_error && (error_count != '1)) begin
      error_count <= error_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_rx_deserializer.sv
// Self-checking bench for ddr_rx_deserializer: directed and randomized beats against a frame-level model.
// Error counter checks are active when DDR_RX_DESERIALIZER_ERROR_COUNT_EN is defined.
module tb_ddr_rx_deserializer;

  localparam int DW = 4;
  localparam int CW = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [DW-1:0]   ddr_data = '0;
  logic            ddr_control = 1'b0;
  logic            nibble_mode = 1'b0;
  logic [2*DW-1:0] output_data;
  logic            output_valid;
  logic            output_error;
  logic            frame_start;
  logic            frame_end;
`ifdef DDR_RX_DESERIALIZER_ERROR_COUNT_EN
  logic [CW-1:0]   error_count;
`endif

  ddr_rx_deserializer #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ddr_data    (ddr_data),
    .ddr_control (ddr_control),
    .nibble_mode (nibble_mode),
    .output_data (output_data),
    .output_valid(output_valid),
    .output_error(output_error),
    .frame_start (frame_start),
    .frame_end   (frame_end)
`ifdef DDR_RX_DESERIALIZER_ERROR_COUNT_EN
    ,
    .error_count (error_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] rd;
    logic          rc;
    logic [DW-1:0] fd;
    logic          fc;
    logic          nib;
    logic [31:0]   bc;
  } beat_t;

  typedef struct packed {
    logic [2*DW-1:0] data;
    logic            valid;
    logic            err;
    logic            fs;
    logic            fe;
    logic [31:0]     cyc;
  } ev_t;

  beat_t bq[$];
  ev_t   got[$];
  ev_t   expq[$];

  logic [31:0]     cyc = '0;
  int              total = 0;
  int              bad = 0;
  logic [2*DW-1:0] model_last = '0;
  int              err_total = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset && (output_valid || output_error || frame_start || frame_end))
      got.push_back('{output_data, output_valid, output_error, frame_start, frame_end, cyc});
  end

`ifdef DDR_RX_DESERIALIZER_ERROR_COUNT_EN
  function automatic logic [CW-1:0] sat_count();
    int mx;
    mx = (1 << CW) - 1;
    return (err_total >= mx) ? CW'(mx) : CW'(err_total);
  endfunction
`endif

  task automatic send(input logic [DW-1:0] rd, input logic rc, input logic [DW-1:0] fd, input logic fc);
    beat_t b;
    ddr_data    = rd;
    ddr_control = rc;
    @(posedge clock);
    #1;
    b = '{rd, rc, fd, fc, nibble_mode, cyc};
    bq.push_back(b);
    ddr_data    = fd;
    ddr_control = fc;
    @(negedge clock);
    #1;
  endtask

  task automatic push_ev(input logic [2*DW-1:0] d, input logic v, input logic e,
                         input logic fs, input logic fe, input logic [31:0] c);
    if (v) model_last = d;
    if (e) err_total++;
    expq.push_back('{model_last, v, e, fs, fe, c});
  endtask

  // Frame-level model: split the beat list into runs of dv=1 beats and
  // derive words, pairing and end-of-frame events from each run.
  task automatic build_expected(input bit start_sync);
    int  n;
    int  i;
    bit  synced;
    n = bq.size();
    i = 0;
    synced = !start_sync;
    while (i < n) begin
      if (!synced) begin
        if (!bq[i].rc) synced = 1;
        i++;
      end else if (!bq[i].rc) begin
        i++;
      end else begin
        int j;
        int len;
        j = i;
        while (j < n && bq[j].rc) j++;
        len = j - i;
        if (!bq[i].nib) begin
          for (int k = i; k < j; k++)
            push_ev({bq[k].fd, bq[k].rd}, 1'b1, bq[k].rc ^ bq[k].fc, k == i, 1'b0, bq[k].bc + 1);
        end else begin
          for (int p = 0; p + 1 < len; p += 2)
            push_ev({bq[i+p+1].rd, bq[i+p].rd}, 1'b1,
                    (bq[i+p].rc ^ bq[i+p].fc) | (bq[i+p+1].rc ^ bq[i+p+1].fc),
                    p == 0, 1'b0, bq[i+p+1].bc + 1);
        end
        if (j < n) begin
          push_ev(model_last, 1'b0, bq[i].nib && (len % 2 == 1), 1'b0, 1'b1, bq[j].bc + 1);
          i = j + 1;
        end else begin
          i = j;
        end
      end
    end
  endtask

  task automatic clear_logs();
    bq.delete();
    got.delete();
    expq.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++; if (output_data !== '0) begin bad++; $display("FAIL reset data: got %h expected 00", output_data); end
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL reset valid: got %b expected 0", output_valid); end
    total++; if (output_error !== 1'b0) begin bad++; $display("FAIL reset error: got %b expected 0", output_error); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset frame_start: got %b expected 0", frame_start); end
    total++; if (frame_end !== 1'b0) begin bad++; $display("FAIL reset frame_end: got %b expected 0", frame_end); end
`ifdef DDR_RX_DESERIALIZER_ERROR_COUNT_EN
    total++; if (error_count !== '0) begin bad++; $display("FAIL reset error_count: got %0d expected 0", error_count); end
`endif
    ddr_control = 1'b1;
    ddr_data    = DW'($urandom);
    repeat (3) @(negedge clock);
    total++;
    if (output_valid !== 1'b0 || output_data !== '0) begin
      bad++;
      $display("FAIL reset with dv high: got valid=%b data=%h expected 0/00", output_valid, output_data);
    end
    #1;
    ddr_control = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_ddr_basic();
    clear_logs();
    nibble_mode = 1'b0;
    send('0, 1'b0, '0, 1'b0);
    send(4'h5, 1'b1, 4'hA, 1'b1);
    send(4'h3, 1'b1, 4'hC, 1'b1);
    send('0, 1'b0, '0, 1'b0);
    send('0, 1'b0, '0, 1'b0);
    build_expected(1'b1);
    total++;
    if (got.size() != expq.size()) begin
      bad++;
      $display("FAIL ddr_basic event count: got %0d expected %0d", got.size(), expq.size());
    end
    for (int k = 0; k < got.size() && k < expq.size(); k++) begin
      total++;
      if (got[k] !== expq[k]) begin
        bad++;
        $display("FAIL ddr_basic event %0d: got d=%h v=%b e=%b fs=%b fe=%b c=%0d expected d=%h v=%b e=%b fs=%b fe=%b c=%0d",
                 k, got[k].data, got[k].valid, got[k].err, got[k].fs, got[k].fe, got[k].cyc,
                 expq[k].data, expq[k].valid, expq[k].err, expq[k].fs, expq[k].fe, expq[k].cyc);
      end
    end
    if (got.size() == 3) begin
      total++;
      if (got[0].data !== 8'hA5 || got[0].fs !== 1'b1 || got[0].err !== 1'b0) begin
        bad++; $display("FAIL ddr_basic first word: got %h fs=%b e=%b expected a5 fs=1 e=0", got[0].data, got[0].fs, got[0].err);
      end
      total++;
      if (got[1].data !== 8'hC3 || got[2].fe !== 1'b1 || got[2].cyc !== got[1].cyc + 1) begin
        bad++; $display("FAIL ddr_basic tail: got %h fe=%b expected c3 then frame_end next cycle", got[1].data, got[2].fe);
      end
    end
  endtask

  task automatic test_nibble_basic();
    clear_logs();
    nibble_mode = 1'b1;
    for (int n = 1; n <= 4; n++) send(DW'(n), 1'b1, DW'($urandom), 1'b1);
    send('0, 1'b0, '0, 1'b0);
    send('0, 1'b0, '0, 1'b0);
    for (int n = 5; n <= 7; n++) send(DW'(n), 1'b1, DW'($urandom), 1'b1);
    send('0, 1'b0, '0, 1'b0);
    send('0, 1'b0, '0, 1'b0);
    build_expected(1'b0);
    total++;
    if (got.size() != expq.size()) begin
      bad++;
      $display("FAIL nibble_basic event count: got %0d expected %0d", got.size(), expq.size());
    end
    for (int k = 0; k < got.size() && k < expq.size(); k++) begin
      total++;
      if (got[k] !== expq[k]) begin
        bad++;
        $display("FAIL nibble_basic event %0d: got d=%h v=%b e=%b fs=%b fe=%b c=%0d expected d=%h v=%b e=%b fs=%b fe=%b c=%0d",
                 k, got[k].data, got[k].valid, got[k].err, got[k].fs, got[k].fe, got[k].cyc,
                 expq[k].data, expq[k].valid, expq[k].err, expq[k].fs, expq[k].fe, expq[k].cyc);
      end
    end
    if (got.size() == 5) begin
      total++;
      if (got[0].data !== 8'h21 || got[1].data !== 8'h43 || got[1].cyc !== got[0].cyc + 2) begin
        bad++; $display("FAIL nibble_pairs: got %h,%h gap %0d expected 21,43 gap 2", got[0].data, got[1].data, got[1].cyc - got[0].cyc);
      end
      total++;
      if (got[4].fe !== 1'b1 || got[4].err !== 1'b1 || got[4].valid !== 1'b0) begin
        bad++; $display("FAIL nibble_odd: got fe=%b e=%b v=%b expected 1 1 0", got[4].fe, got[4].err, got[4].valid);
      end
    end
`ifdef DDR_RX_DESERIALIZER_ERROR_COUNT_EN
    total++; if (error_count !== sat_count()) begin bad++; $display("FAIL nibble_basic error_count: got %0d expected %0d", error_count, sat_count()); end
`endif
  endtask

  task automatic test_error_count();
    clear_logs();
    nibble_mode = 1'b0;
    send(4'h9, 1'b1, 4'h6, 1'b0);
    send('0, 1'b0, '0, 1'b0);
    send('0, 1'b0, '0, 1'b0);
`ifdef DDR_RX_DESERIALIZER_ERROR_COUNT_EN
    total++; if (error_count !== 3'd2) begin bad++; $display("FAIL error_count step: got %0d expected 2", error_count); end
`endif
    repeat (9) send(DW'($urandom), 1'b1, DW'($urandom), 1'b0);
    send('0, 1'b0, '0, 1'b0);
    send('0, 1'b0, '0, 1'b0);
    build_expected(1'b0);
    total++;
    if (got.size() != expq.size()) begin
      bad++;
      $display("FAIL error_words event count: got %0d expected %0d", got.size(), expq.size());
    end
    for (int k = 0; k < got.size() && k < expq.size(); k++) begin
      total++;
      if (got[k] !== expq[k]) begin
        bad++;
        $display("FAIL error_words event %0d: got d=%h v=%b e=%b fs=%b fe=%b c=%0d expected d=%h v=%b e=%b fs=%b fe=%b c=%0d",
                 k, got[k].data, got[k].valid, got[k].err, got[k].fs, got[k].fe, got[k].cyc,
                 expq[k].data, expq[k].valid, expq[k].err, expq[k].fs, expq[k].fe, expq[k].cyc);
      end
    end
`ifdef DDR_RX_DESERIALIZER_ERROR_COUNT_EN
    total++; if (error_count !== '1) begin bad++; $display("FAIL error_count saturate: got %0d expected %0d", error_count, sat_count()); end
`endif
  endtask

  task automatic test_back_to_back();
    clear_logs();
    nibble_mode = 1'b0;
    repeat (2) send(DW'($urandom), 1'b1, DW'($urandom), 1'b1);
    send('0, 1'b0, '0, 1'b0);
    send(DW'($urandom), 1'b1, DW'($urandom), 1'b1);
    send('0, 1'b0, '0, 1'b0);
    send('0, 1'b0, '0, 1'b0);
    nibble_mode = 1'b1;
    repeat (2) send(DW'($urandom), 1'b1, DW'($urandom), 1'b1);
    send('0, 1'b0, '0, 1'b0);
    repeat (4) send(DW'($urandom), 1'b1, DW'($urandom), 1'b1);
    send('0, 1'b0, '0, 1'b0);
    send('0, 1'b0, '0, 1'b0);
    build_expected(1'b0);
    total++;
    if (got.size() != expq.size()) begin
      bad++;
      $display("FAIL back_to_back event count: got %0d expected %0d", got.size(), expq.size());
    end
    for (int k = 0; k < got.size() && k < expq.size(); k++) begin
      total++;
      if (got[k] !== expq[k]) begin
        bad++;
        $display("FAIL back_to_back event %0d: got d=%h v=%b e=%b fs=%b fe=%b c=%0d expected d=%h v=%b e=%b fs=%b fe=%b c=%0d",
                 k, got[k].data, got[k].valid, got[k].err, got[k].fs, got[k].fe, got[k].cyc,
                 expq[k].data, expq[k].valid, expq[k].err, expq[k].fs, expq[k].fe, expq[k].cyc);
      end
    end
  endtask

  task automatic test_random();
    bit prev1;
    bit prev2;
    clear_logs();
    prev1 = 1'b0;
    prev2 = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic dv;
      logic e;
      if (!prev1 && !prev2 && ($urandom % 3 == 0)) nibble_mode = ~nibble_mode;
      dv = ($urandom % 4) != 0;
      e  = ($urandom % 6) == 0;
      send(DW'($urandom), dv, DW'($urandom), dv ^ e);
      prev2 = prev1;
      prev1 = dv;
    end
    send('0, 1'b0, '0, 1'b0);
    send('0, 1'b0, '0, 1'b0);
    build_expected(1'b0);
    total++;
    if (got.size() != expq.size()) begin
      bad++;
      $display("FAIL random event count: got %0d expected %0d", got.size(), expq.size());
    end
    for (int k = 0; k < got.size() && k < expq.size(); k++) begin
      total++;
      if (got[k] !== expq[k]) begin
        bad++;
        $display("FAIL random event %0d: got d=%h v=%b e=%b fs=%b fe=%b c=%0d expected d=%h v=%b e=%b fs=%b fe=%b c=%0d",
                 k, got[k].data, got[k].valid, got[k].err, got[k].fs, got[k].fe, got[k].cyc,
                 expq[k].data, expq[k].valid, expq[k].err, expq[k].fs, expq[k].fe, expq[k].cyc);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    nibble_mode = 1'b0;
    send('0, 1'b0, '0, 1'b0);
    repeat (3) send(DW'($urandom), 1'b1, DW'($urandom), 1'b1);
    reset = 1'b1;
    void'(bq.pop_back());
    build_expected(1'b0);
    total++;
    if (got.size() != expq.size()) begin
      bad++;
      $display("FAIL pre_reset event count: got %0d expected %0d", got.size(), expq.size());
    end
    for (int k = 0; k < got.size() && k < expq.size(); k++) begin
      total++;
      if (got[k] !== expq[k]) begin
        bad++;
        $display("FAIL pre_reset event %0d: got d=%h v=%b e=%b fs=%b fe=%b c=%0d expected d=%h v=%b e=%b fs=%b fe=%b c=%0d",
                 k, got[k].data, got[k].valid, got[k].err, got[k].fs, got[k].fe, got[k].cyc,
                 expq[k].data, expq[k].valid, expq[k].err, expq[k].fs, expq[k].fe, expq[k].cyc);
      end
    end
    ddr_control = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (output_data !== '0 || output_valid !== 1'b0 || frame_end !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset outputs: got d=%h v=%b fe=%b expected 00 0 0", output_data, output_valid, frame_end);
    end
    #1;
    reset = 1'b0;
    model_last = '0;
    err_total = 0;
    clear_logs();
    repeat (3) send(DW'($urandom), 1'b1, DW'($urandom), 1'b1);
    send('0, 1'b0, '0, 1'b0);
    repeat (2) send(DW'($urandom), 1'b1, DW'($urandom), 1'b1);
    send('0, 1'b0, '0, 1'b0);
    send('0, 1'b0, '0, 1'b0);
    build_expected(1'b1);
    total++;
    if (got.size() != expq.size()) begin
      bad++;
      $display("FAIL post_reset event count: got %0d expected %0d", got.size(), expq.size());
    end
    for (int k = 0; k < got.size() && k < expq.size(); k++) begin
      total++;
      if (got[k] !== expq[k]) begin
        bad++;
        $display("FAIL post_reset event %0d: got d=%h v=%b e=%b fs=%b fe=%b c=%0d expected d=%h v=%b e=%b fs=%b fe=%b c=%0d",
                 k, got[k].data, got[k].valid, got[k].err, got[k].fs, got[k].fe, got[k].cyc,
                 expq[k].data, expq[k].valid, expq[k].err, expq[k].fs, expq[k].fe, expq[k].cyc);
      end
    end
`ifdef DDR_RX_DESERIALIZER_ERROR_COUNT_EN
    total++; if (error_count !== sat_count()) begin bad++; $display("FAIL post_reset error_count: got %0d expected %0d", error_count, sat_count()); end
`endif
  endtask

  initial begin
    test_reset();
    test_ddr_basic();
    test_nibble_basic();
    test_error_count();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_rx_deserializer.md
DDR_RX_DESERIALIZER -- requirements
Module: ddr_rx_deserializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, giving the per-edge data width.
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 16, giving the error counter width.
REQ-003 The block SHALL have port clock, input, 1, the single clock; data is sampled on both of its edges.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port ddr_data, input, DATA_WIDTH, DDR data pins.
REQ-006 The block SHALL have port ddr_control, input, 1, DDR control pin: rise = data valid (dv), fall = dv XOR error.
REQ-007 The block SHALL have port nibble_mode, input, 1: 0 = DDR byte per cycle, 1 = rising-edge-only nibble pairing; quasi-static, sampled only in IDLE.
REQ-008 The block SHALL have port output_data, output, 2*DATA_WIDTH, assembled word.
REQ-009 The block SHALL have port output_valid, output, 1, output_data qualifier.
REQ-010 The block SHALL have port output_error, output, 1, error flag on a valid word or on a truncated frame.
REQ-011 The block SHALL have port frame_start, output, 1, one-cycle pulse coincident with the first output_valid of a frame.
REQ-012 The block SHALL have port frame_end, output, 1, one-cycle pulse on the first cycle after a frame's last beat.
REQ-013 The block SHALL have port error_count, output, COUNT_WIDTH, present only under REQ-033.

Function
REQ-014 The block SHALL capture ddr_data/ddr_control on posedge into rise registers and on the following negedge into fall registers; the pair forms beat k.
REQ-015 Beat k SHALL have dv = rise control and error = rise control XOR fall control.
REQ-016 All outputs SHALL be registered on posedge clock; no output SHALL change on negedge.
REQ-017 In DDR mode output_data SHALL be {fall data, rise data} of beat k, with output_valid high in the cycle after posedge k+1 (1-cycle latency).
REQ-018 In nibble mode the low half SHALL be rise data of the first dv beat and the high half the rise data of the next dv beat; fall data SHALL be ignored; output SHALL appear after posedge k+2 of the first beat.
REQ-019 In nibble mode output_error SHALL be the OR of both constituent beats' error.
REQ-020 The FSM SHALL have states SYNC, IDLE, DDR_ACTIVE, NIBBLE_LOW, NIBBLE_HIGH.
REQ-021 SYNC SHALL go to IDLE on the first beat with dv=0; beats in SYNC SHALL produce no output.
REQ-022 IDLE on a dv=1 beat SHALL go to DDR_ACTIVE (nibble_mode=0, word emitted) or NIBBLE_HIGH (nibble_mode=1, low nibble stored); nibble_mode SHALL be latched at this transition.
REQ-023 NIBBLE_HIGH on a dv=1 beat SHALL emit the word and go to NIBBLE_LOW; NIBBLE_LOW on a dv=1 beat SHALL store the low nibble and go to NIBBLE_HIGH.
REQ-024 In any active state a dv=0 beat SHALL return to IDLE and pulse frame_end.
REQ-025 A dv=0 beat in NIBBLE_HIGH (odd nibble count) SHALL discard the stored nibble and assert output_error with frame_end, output_valid low.
REQ-026 A dv=1 beat in IDLE immediately following frame_end SHALL start a new frame (back-to-back frames, no gap required).
REQ-027 output_data SHALL hold its last value when output_valid is low.

Reset
REQ-028 While reset is high, output_data, output_valid, output_error, frame_start, frame_end and error_count SHALL be 0.
REQ-029 While reset is high, capture registers SHALL be 0 and the FSM SHALL be in SYNC.
REQ-030 Reset assertion mid-frame SHALL abandon the frame without a frame_end pulse.
REQ-031 After reset deassertion a frame already in progress SHALL be ignored until dv=0 is seen (REQ-021).

Configuration
REQ-032 Macro DDR_RX_DESERIALIZER_ERROR_COUNT_EN SHALL select the error counter feature.
REQ-033 With the macro defined, error_count SHALL increment by 1 each cycle output_error=1, saturate at all-ones and clear only on reset.
REQ-034 Without the macro, the error_count port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 DDR mode, beats rise=0x5/fall=0xA, rise=0x3/fall=0xC with ctl rise=1/fall=1 -> output_data 0xA5 then 0xC3, error 0, frame_start on 0xA5, frame_end after.
REQ-036 Nibble mode, rise nibbles 0x1,0x2,0x3,0x4 with dv -> bytes 0x21, 0x43, each two cycles apart.
REQ-037 Nibble mode, three dv nibbles then dv=0 -> one byte, then frame_end with output_error=1 and output_valid=0.
REQ-038 DDR beat with ctl rise=1/fall=0 -> that word output_error=1; with macro, error_count increments by 1; forced count of all-ones stays saturated.
REQ-039 Reset asserted mid-frame and released while dv=1 -> no output until a dv=0 beat, then the next frame is received normally.
